// File: rtl/pic_host_pkg.sv
// pic_host_pkg: shared types and constants for the PIC host controller.
//   state_t     - controller FSM states
//   op_t        - kind of write sequence in flight (init list or EOI)
//   ICW1_SINGLE - ICW1 byte: edge triggered, single PIC, ICW4 needed
//   OCW2_NS_EOI - OCW2 byte: non-specific EOI
//   INIT_LEN    - number of bytes in the init list (ICW1, ICW2, ICW4, OCW1)
//   init_byte() - byte for a given init-list position
package pic_host_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        GAP,
        ACK1,
        ACK_GAP,
        ACK2,
        VEC_HOLD
    } state_t;

    typedef enum logic {
        OP_INIT,
        OP_EOI
    } op_t;

    localparam logic [7:0] ICW1_SINGLE = 8'h13;
    localparam logic [7:0] OCW2_NS_EOI = 8'h20;
    localparam int         INIT_LEN    = 4;

    function automatic logic [7:0] init_byte(input logic [1:0] idx,
                                             input logic [4:0] base,
                                             input logic [7:0] icw4,
                                             input logic [7:0] imr);
        case (idx)
            2'd0:    return ICW1_SINGLE;
            2'd1:    return {base, 3'b000};
            2'd2:    return icw4;
            default: return imr;
        endcase
    endfunction

endpackage

// File: rtl/pic_bus_strobe.sv
// pic_bus_strobe: timed phase generator shared by PIC write and INTA cycles.
// A start pulse loads a down-counter with the pulse or gap length; the phase
// ends on the cycle the counter reads zero.
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - load a new phase (asserted on the edge entering it)
//   start_gap   - 1: the new phase is a recovery gap, 0: a low strobe
//   strobe_low  - high for every cycle of a strobe phase
//   phase_done  - high on the last cycle of the current phase
module pic_bus_strobe #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic start_gap,
    output logic strobe_low,
    output logic phase_done
);

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            strobe_low <= 1'b0;
        end else if (start) begin
            cnt        <= start_gap ? GAP_LOAD : PULSE_LOAD;
            strobe_low <= !start_gap;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end else begin
            strobe_low <= 1'b0;
        end
    end

    assign phase_done = (cnt == 4'd0);

endmodule

// File: rtl/pic_host_ctrl.sv
// pic_host_ctrl: CPU-side initiator for an 8259-compatible PIC.
// Programs the PIC (ICW1, ICW2, ICW4, OCW1) on cfg_start, answers intr with
// the two-pulse INTA sequence, hands the vector to the core over
// vec_valid/vec_ready and issues a non-specific EOI on eoi_req.
// Optional build macro PIC_HOST_SPUR_DET_EN adds vec_spur (spurious IR7 flag).
//   clk, rst_n          - clock, synchronous active-low reset
//   cs_n/wr_n/rd_n/a1   - PIC bus control (rd_n is never asserted)
//   data_out, data_oe   - byte toward the PIC and its drive enable
//   data_in             - byte from the PIC bus (vector during INTA)
//   intr, inta_n        - PIC interrupt request / acknowledge
//   cfg_start, vec_base - start initialisation with vector base T7..T3
//   cfg_done            - initialisation completed
//   vec_valid/vec_data/vec_ready - vector handshake to the core
//   eoi_req, eoi_done   - EOI request / completion pulse
//   busy                - FSM not idle
//
// state     | meaning
// IDLE      | arbitrate pending cfg > EOI > acknowledge
// WR_SETUP  | cs_n low, address/data driven, wr_n high
// WR_STROBE | wr_n low for PULSE_CYCLES
// WR_HOLD   | wr_n high, cs_n/data held
// GAP       | all strobes high for GAP_CYCLES, then next init byte or IDLE
// ACK1      | first inta_n pulse
// ACK_GAP   | inta_n high between the pulses
// ACK2      | second inta_n pulse, vector captured on its last cycle
// VEC_HOLD  | vec_valid high until the core takes the vector
module pic_host_ctrl
    import pic_host_pkg::*;
#(
    parameter int         PULSE_CYCLES = 2,
    parameter int         GAP_CYCLES   = 1,
    parameter logic [7:0] ICW4_VAL     = 8'h01,
    parameter logic [7:0] IMR_INIT     = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a1,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    input  logic       intr,
    output logic       inta_n,
    input  logic       cfg_start,
    input  logic [4:0] vec_base,
    output logic       cfg_done,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    input  logic       vec_ready,
    input  logic       eoi_req,
    output logic       eoi_done,
    output logic       busy
`ifdef PIC_HOST_SPUR_DET_EN
    ,
    output logic       vec_spur
`endif
);

    localparam logic [1:0] INIT_LAST = 2'(INIT_LEN - 1);

    state_t     state, state_nx;
    op_t        op_q;
    logic [1:0] idx_q;
    logic [7:0] byte_q;
    logic       a1_q;
    logic [4:0] base_q, pend_base;
    logic       cfg_pend, eoi_pend;
    logic       intr_s1, intr_s2;
    logic       cfg_done_q, vec_valid_q;
    logic [7:0] vec_data_q;

    logic       take_cfg, take_eoi, next_init;
    logic       strb_start, strb_gap, strobe_low, phase_done;
    logic       wr_bus, capture;

    pic_bus_strobe #(
        .PULSE_CYCLES(PULSE_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_strobe (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (strb_start),
        .start_gap (strb_gap),
        .strobe_low(strobe_low),
        .phase_done(phase_done)
    );

    always_comb begin
        state_nx   = state;
        take_cfg   = 1'b0;
        take_eoi   = 1'b0;
        next_init  = 1'b0;
        strb_start = 1'b0;
        strb_gap   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start || cfg_pend) begin
                    take_cfg = 1'b1;
                    state_nx = WR_SETUP;
                end else if (eoi_req || eoi_pend) begin
                    take_eoi = 1'b1;
                    state_nx = WR_SETUP;
                end else if (cfg_done_q && intr_s2 && !vec_valid_q) begin
                    state_nx   = ACK1;
                    strb_start = 1'b1;
                end
            end
            WR_SETUP: begin
                state_nx   = WR_STROBE;
                strb_start = 1'b1;
            end
            WR_STROBE: if (phase_done) state_nx = WR_HOLD;
            WR_HOLD: begin
                state_nx   = GAP;
                strb_start = 1'b1;
                strb_gap   = 1'b1;
            end
            GAP: begin
                if (phase_done) begin
                    if (op_q == OP_INIT && idx_q != INIT_LAST) begin
                        next_init = 1'b1;
                        state_nx  = WR_SETUP;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            ACK1: begin
                if (phase_done) begin
                    state_nx   = ACK_GAP;
                    strb_start = 1'b1;
                    strb_gap   = 1'b1;
                end
            end
            ACK_GAP: begin
                if (phase_done) begin
                    state_nx   = ACK2;
                    strb_start = 1'b1;
                end
            end
            ACK2:     if (phase_done) state_nx = VEC_HOLD;
            VEC_HOLD: if (vec_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    assign capture = (state == ACK2) && phase_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= OP_INIT;
            idx_q       <= 2'd0;
            byte_q      <= 8'h00;
            a1_q        <= 1'b0;
            base_q      <= 5'd0;
            pend_base   <= 5'd0;
            cfg_pend    <= 1'b0;
            eoi_pend    <= 1'b0;
            intr_s1     <= 1'b0;
            intr_s2     <= 1'b0;
            cfg_done_q  <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_data_q  <= 8'h00;
        end else begin
            state   <= state_nx;
            intr_s1 <= intr;
            intr_s2 <= intr_s1;

            // A pulse served directly from IDLE is never latched; a repeat
            // pulse while one is pending is dropped.
            if (take_cfg) begin
                cfg_pend <= 1'b0;
            end else if (cfg_start && !cfg_pend) begin
                cfg_pend  <= 1'b1;
                pend_base <= vec_base;
            end
            if (take_eoi) eoi_pend <= 1'b0;
            else if (eoi_req) eoi_pend <= 1'b1;

            if (take_cfg) begin
                op_q   <= OP_INIT;
                idx_q  <= 2'd0;
                base_q <= cfg_pend ? pend_base : vec_base;
                byte_q <= ICW1_SINGLE;
                a1_q   <= 1'b0;
            end else if (take_eoi) begin
                op_q   <= OP_EOI;
                byte_q <= OCW2_NS_EOI;
                a1_q   <= 1'b0;
            end else if (next_init) begin
                idx_q  <= idx_q + 2'd1;
                byte_q <= init_byte(idx_q + 2'd1, base_q, ICW4_VAL, IMR_INIT);
                a1_q   <= 1'b1;
            end

            if (state == GAP && phase_done && op_q == OP_INIT && idx_q == INIT_LAST)
                cfg_done_q <= 1'b1;

            if (capture) begin
                vec_data_q  <= data_in;
                vec_valid_q <= 1'b1;
            end else if (state == VEC_HOLD && vec_ready) begin
                vec_valid_q <= 1'b0;
            end
        end
    end

`ifdef PIC_HOST_SPUR_DET_EN
    // intr is sampled on the first ACK2 cycle; with a one-cycle pulse that
    // cycle is also the capture cycle, so the live value is used directly.
    logic ack2_first, intr_at_ack2, intr_seen, vec_spur_q;

    assign intr_seen = ack2_first ? intr_s2 : intr_at_ack2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack2_first   <= 1'b0;
            intr_at_ack2 <= 1'b0;
            vec_spur_q   <= 1'b0;
        end else begin
            ack2_first <= (state_nx == ACK2) && (state != ACK2);
            if (state == ACK2 && ack2_first) intr_at_ack2 <= intr_s2;
            if (capture) vec_spur_q <= !intr_seen && (data_in[2:0] == 3'b111);
            else if (state == VEC_HOLD && vec_ready) vec_spur_q <= 1'b0;
        end
    end

    assign vec_spur = vec_spur_q;
`endif

    assign wr_bus    = (state == WR_SETUP) || (state == WR_STROBE) || (state == WR_HOLD);
    assign cs_n      = !wr_bus;
    assign data_oe   = wr_bus;
    assign a1        = wr_bus && a1_q;
    assign data_out  = wr_bus ? byte_q : 8'h00;
    assign wr_n      = !(strobe_low && state == WR_STROBE);
    assign inta_n    = !(strobe_low && (state == ACK1 || state == ACK2));
    assign rd_n      = 1'b1;
    assign eoi_done  = (state == GAP) && phase_done && (op_q == OP_EOI);
    assign busy      = (state != IDLE);
    assign cfg_done  = cfg_done_q;
    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_data_q;

endmodule

// File: tb/tb_pic_host_ctrl.sv
module tb_pic_host_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n, wr_n, rd_n, a1, data_oe, inta_n;
    logic [7:0] data_out, vec_data;
    logic [7:0] data_in = 8'h00;
    logic       intr = 1'b0, cfg_start = 1'b0, vec_ready = 1'b0, eoi_req = 1'b0;
    logic [4:0] vec_base = 5'd0;
    logic       cfg_done, vec_valid, eoi_done, busy;
`ifdef PIC_HOST_SPUR_DET_EN
    logic       vec_spur;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pic_host_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .wr_n     (wr_n),
        .rd_n     (rd_n),
        .a1       (a1),
        .data_out (data_out),
        .data_oe  (data_oe),
        .data_in  (data_in),
        .intr     (intr),
        .inta_n   (inta_n),
        .cfg_start(cfg_start),
        .vec_base (vec_base),
        .cfg_done (cfg_done),
        .vec_valid(vec_valid),
        .vec_data (vec_data),
        .vec_ready(vec_ready),
        .eoi_req  (eoi_req),
        .eoi_done (eoi_done),
        .busy     (busy)
`ifdef PIC_HOST_SPUR_DET_EN
        ,
        .vec_spur (vec_spur)
`endif
    );

    // Bus monitor: records every completed write strobe and INTA pulse.
    int         nwr = 0, nia = 0, neoi = 0, bus_bad = 0;
    int         wr_w = 0, ia_w = 0, ia_gap = 0;
    logic [7:0] wr_b_cur = 8'h00;
    logic       wr_a1_cur = 1'b0, wr_ok_cur = 1'b0;
    logic [7:0] wr_b_a  [64];
    logic       wr_a1_a [64];
    logic       wr_ok_a [64];
    int         wr_w_a  [64];
    int         ia_w_a  [64];
    int         ia_gap_a[64];

    always @(negedge clk) begin
        if (wr_n === 1'b0) begin
            wr_w++;
            wr_b_cur  = data_out;
            wr_a1_cur = a1;
            wr_ok_cur = (cs_n === 1'b0) && (data_oe === 1'b1);
        end else if (wr_w != 0) begin
            if (nwr < 64) begin
                wr_b_a[nwr]  = wr_b_cur;
                wr_a1_a[nwr] = wr_a1_cur;
                wr_ok_a[nwr] = wr_ok_cur;
                wr_w_a[nwr]  = wr_w;
            end
            nwr++;
            wr_w = 0;
        end
        if (inta_n === 1'b0) begin
            if (ia_w == 0 && nia < 64) ia_gap_a[nia] = ia_gap;
            ia_w++;
            ia_gap = 0;
            if (cs_n !== 1'b1 || data_oe !== 1'b0) bus_bad++;
        end else begin
            if (ia_w != 0) begin
                if (nia < 64) ia_w_a[nia] = ia_w;
                nia++;
                ia_w = 0;
            end
            ia_gap++;
        end
        if (eoi_done === 1'b1) neoi++;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_vec_valid(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (vec_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_inta_low(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (inta_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_ready;
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cs_n, wr_n, rd_n, inta_n} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 1111", {cs_n, wr_n, rd_n, inta_n});
        end
        checks++;
        if ({a1, data_oe, cfg_done, vec_valid, eoi_done, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {a1, data_oe, cfg_done, vec_valid, eoi_done, busy});
        end
        checks++;
        if (data_out !== 8'h00 || vec_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h/%h expected 00/00", data_out, vec_data);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_init;
        int         b_wr, n;
        logic [7:0] exp_b [4];
        logic       exp_a1[4];
        exp_b  = '{8'h13, 8'h40, 8'h01, 8'h00};
        exp_a1 = '{1'b0, 1'b1, 1'b1, 1'b1};
        b_wr = nwr;
        vec_base  = 5'b01000;
        cfg_start = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cfg_start = 1'b0;
            n++;
            if (cfg_done === 1'b1) break;
        end
        checks++;
        if (n != 21) begin
            errors++;
            $display("FAIL init_done_cycle: got %0d expected 21", n);
        end
        checks++;
        if (nwr - b_wr != 4) begin
            errors++;
            $display("FAIL init_write_count: got %0d expected 4", nwr - b_wr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_b_a[b_wr+i] !== exp_b[i] || wr_a1_a[b_wr+i] !== exp_a1[i] ||
                    wr_w_a[b_wr+i] != 2 || wr_ok_a[b_wr+i] !== 1'b1) begin
                    errors++;
                    $display("FAIL init_write%0d: got byte %h a1 %b width %0d bus %b expected %h %b 2 1",
                             i, wr_b_a[b_wr+i], wr_a1_a[b_wr+i], wr_w_a[b_wr+i], wr_ok_a[b_wr+i],
                             exp_b[i], exp_a1[i]);
                end
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL init_idle: got busy %b cfg_done %b expected 0 1", busy, cfg_done);
        end
    endtask

    task automatic test_ack;
        int   b_ia;
        logic ok;
        b_ia = nia;
        data_in = 8'h43;
        intr = 1'b1;
        wait_inta_low(20, ok);
        intr = 1'b0;
        wait_vec_valid(30, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ack_timeout: got no vec_valid expected vec_valid=1");
        end
        checks++;
        if (nia - b_ia != 2 || ia_w_a[b_ia] != 2 || ia_w_a[b_ia+1] != 2 || ia_gap_a[b_ia+1] != 1) begin
            errors++;
            $display("FAIL ack_pulses: got n=%0d w=%0d,%0d gap=%0d expected 2 w=2,2 gap=1",
                     nia - b_ia, ia_w_a[b_ia], ia_w_a[b_ia+1], ia_gap_a[b_ia+1]);
        end
        checks++;
        if (vec_data !== 8'h43 || bus_bad != 0) begin
            errors++;
            $display("FAIL ack_vector: got %h bus_bad %0d expected 43 0", vec_data, bus_bad);
        end
`ifdef PIC_HOST_SPUR_DET_EN
        checks++;
        if (vec_spur !== 1'b0) begin
            errors++;
            $display("FAIL ack_not_spur: got %b expected 0", vec_spur);
        end
`endif
        repeat (3) tick();
        checks++;
        if (vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_hold: got vec_valid %b expected 1", vec_valid);
        end
        pulse_ready();
        checks++;
        if (vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_release: got vec_valid %b expected 0", vec_valid);
        end
        repeat (8) tick();
        checks++;
        if (nia - b_ia != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_quiet: got pulses %0d busy %b expected 2 0", nia - b_ia, busy);
        end
    endtask

    task automatic test_overlap;
        int   b_wr, b_eoi;
        logic ok;
        b_wr = nwr;
        b_eoi = neoi;
        data_in = 8'h44;
        intr = 1'b1;
        wait_inta_low(20, ok);
        eoi_req = 1'b1;
        intr = 1'b0;
        tick();
        eoi_req = 1'b0;
        wait_vec_valid(30, ok);
        checks++;
        if (!ok || vec_data !== 8'h44 || nwr != b_wr) begin
            errors++;
            $display("FAIL overlap_ack_first: got valid %b data %h writes %0d expected 1 44 0",
                     vec_valid, vec_data, nwr - b_wr);
        end
        pulse_ready();
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (neoi != b_eoi) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL overlap_eoi_timeout: got no eoi_done expected a pulse");
        end
        repeat (5) tick();
        checks++;
        if (nwr - b_wr != 1 || neoi - b_eoi != 1) begin
            errors++;
            $display("FAIL overlap_counts: got writes %0d eoi %0d expected 1 1", nwr - b_wr, neoi - b_eoi);
        end else begin
            checks++;
            if (wr_b_a[b_wr] !== 8'h20 || wr_a1_a[b_wr] !== 1'b0 || wr_w_a[b_wr] != 2) begin
                errors++;
                $display("FAIL overlap_eoi_write: got %h a1 %b width %0d expected 20 0 2",
                         wr_b_a[b_wr], wr_a1_a[b_wr], wr_w_a[b_wr]);
            end
        end
    endtask

    task automatic test_backpressure;
        int   b_ia;
        logic ok;
        data_in = 8'h55;
        intr = 1'b1;
        wait_vec_valid(30, ok);
        checks++;
        if (!ok || vec_data !== 8'h55) begin
            errors++;
            $display("FAIL bp_first: got valid %b data %h expected 1 55", vec_valid, vec_data);
        end
        b_ia = nia;
        repeat (20) tick();
        checks++;
        if (nia != b_ia || ia_w != 0 || vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got extra pulses %0d valid %b expected 0 1", nia - b_ia + ia_w, vec_valid);
        end
        pulse_ready();
        wait_inta_low(10, ok);
        intr = 1'b0;
        wait_vec_valid(30, ok);
        checks++;
        if (!ok || nia - b_ia != 2) begin
            errors++;
            $display("FAIL bp_one_ack: got valid %b pulses %0d expected 1 2", vec_valid, nia - b_ia);
        end
        pulse_ready();
        repeat (10) tick();
        checks++;
        if (nia - b_ia != 2 || busy !== 1'b0 || vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_settle: got pulses %0d busy %b valid %b expected 2 0 0",
                     nia - b_ia, busy, vec_valid);
        end
    endtask

`ifdef PIC_HOST_SPUR_DET_EN
    task automatic test_spurious;
        logic ok;
        data_in = 8'h47;
        intr = 1'b1;
        wait_inta_low(20, ok);
        intr = 1'b0;
        wait_vec_valid(30, ok);
        checks++;
        if (!ok || vec_spur !== 1'b1 || vec_data !== 8'h47) begin
            errors++;
            $display("FAIL spur_flag: got valid %b spur %b data %h expected 1 1 47",
                     vec_valid, vec_spur, vec_data);
        end
        pulse_ready();
        checks++;
        if (vec_spur !== 1'b0) begin
            errors++;
            $display("FAIL spur_clear: got %b expected 0", vec_spur);
        end
        repeat (4) tick();
    endtask
`endif

    task automatic test_reset_mid;
        int   b_wr;
        logic ok;
        b_wr = nwr;
        vec_base  = 5'b01000;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (nwr - b_wr == 1 && wr_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_reach: got no ICW2 strobe expected one");
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({cs_n, wr_n, inta_n, data_oe, cfg_done, busy} !== 6'b111000) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b expected 111000",
                     {cs_n, wr_n, inta_n, data_oe, cfg_done, busy});
        end
        rst_n = 1'b1;
        tick();
        b_wr = nwr;
        repeat (10) tick();
        checks++;
        if (nwr != b_wr || busy !== 1'b0 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_discard: got writes %0d busy %b cfg_done %b expected 0 0 0",
                     nwr - b_wr, busy, cfg_done);
        end
    endtask

    task automatic test_back_to_back;
        int         b_wr, b_eoi;
        logic       ok;
        logic [7:0] exp_b [5];
        logic       exp_a1[5];
        exp_b  = '{8'h13, 8'hA8, 8'h01, 8'h00, 8'h20};
        exp_a1 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        b_wr = nwr;
        b_eoi = neoi;
        vec_base  = 5'b10101;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        eoi_req   = 1'b1;
        tick();
        eoi_req = 1'b0;
        tick();
        eoi_req = 1'b1;
        tick();
        eoi_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (neoi != b_eoi) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: got no eoi_done expected a pulse");
        end
        repeat (6) tick();
        checks++;
        if (nwr - b_wr != 5 || neoi - b_eoi != 1 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_counts: got writes %0d eoi %0d cfg_done %b expected 5 1 1",
                     nwr - b_wr, neoi - b_eoi, cfg_done);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_b_a[b_wr+i] !== exp_b[i] || wr_a1_a[b_wr+i] !== exp_a1[i]) begin
                    errors++;
                    $display("FAIL b2b_write%0d: got %h a1 %b expected %h %b",
                             i, wr_b_a[b_wr+i], wr_a1_a[b_wr+i], exp_b[i], exp_a1[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_ack();
        test_overlap();
        test_backpressure();
`ifdef PIC_HOST_SPUR_DET_EN
        test_spurious();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
